// File: rtl/vga_framebuffer_pkg.sv
// Shared constants and FSM encoding for the double-buffered VGA framebuffer.
// Frame geometry is 64x64; a pixel address is {y[5:0], x[5:0]}.
package vga_framebuffer_pkg;

   localparam int FB_W   = 64;
   localparam int FB_H   = 64;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      CLEAR   = 2'd2
   } fb_state_t;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Holds both banks; the bank select is the address MSB.
module fb_dpram #(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W:0]   wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic [ADDR_W:0]   rd_addr,
   output logic [PIX_W-1:0]  rd_data
);

   logic [PIX_W-1:0] mem [0:(2**(ADDR_W+1))-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Only the output register is cleared so scan-out shows black during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/vga_framebuffer.sv
// Double-buffered 64x64 framebuffer; banks exchange only on a v_sync edge.
// Optional macro FB_AUTO_CLEAR_EN zero-fills the new back bank after each swap.
module vga_framebuffer #(
   parameter int PIX_W            = vga_framebuffer_pkg::PIX_W,
   parameter int ADDR_W           = vga_framebuffer_pkg::ADDR_W,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              busy,
   output logic              front_sel,
   input  logic              v_sync,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [PIX_W-1:0]  vga_data
);

   import vga_framebuffer_pkg::*;

   localparam logic VS_IDLE_LVL = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

   function automatic logic vs_asserted(input logic lvl);
      return VSYNC_ACTIVE_LOW ? ~lvl : lvl;
   endfunction

   fb_state_t         state_q, state_d;
   logic              vs_p0, vs_p1;
   logic              vs_edge;
   logic              swap_fire;
   logic              ram_we;
   logic [ADDR_W:0]   ram_waddr;
   logic [PIX_W-1:0]  ram_wdata;

   // Stage p0 registers v_sync, stage p1 holds the previous sample for edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_p0 <= VS_IDLE_LVL;
         vs_p1 <= VS_IDLE_LVL;
      end else begin
         vs_p0 <= v_sync;
         vs_p1 <= vs_p0;
      end
   end

   assign vs_edge   = vs_asserted(vs_p0) & ~vs_asserted(vs_p1);
   assign swap_fire = (state_q == WAIT_VS) && vs_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         front_sel <= 1'b0;
         swap_ack  <= 1'b0;
      end else begin
         state_q   <= state_d;
         front_sel <= front_sel ^ swap_fire;
         swap_ack  <= swap_fire;
      end
   end

`ifdef FB_AUTO_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt;

   // Counter starts at 0 on entry and wraps back to 0 as CLEAR ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt <= '0;
      end else if (state_q == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      wr_ready = 1'b0;
      busy     = 1'b1;
      case (state_q)
         IDLE: begin
            wr_ready = 1'b1;
            busy     = 1'b0;
            if (swap_req) begin
               state_d = WAIT_VS;
            end
         end
         WAIT_VS: begin
            if (vs_edge) begin
`ifdef FB_AUTO_CLEAR_EN
               state_d = CLEAR;
`else
               state_d = IDLE;
`endif
            end
         end
`ifdef FB_AUTO_CLEAR_EN
         CLEAR: begin
            if (clr_cnt == '1) begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Writes always target the back bank, so they never collide with scan-out.
   always_comb begin
      ram_we    = wr_valid & wr_ready;
      ram_waddr = {~front_sel, wr_addr};
      ram_wdata = wr_data;
`ifdef FB_AUTO_CLEAR_EN
      if (state_q == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = {~front_sel, clr_cnt};
         ram_wdata = '0;
      end
`endif
   end

   fb_dpram #(
      .PIX_W  (PIX_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_addr ({front_sel, vga_addr}),
      .rd_data (vga_data)
   );

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed bench for vga_framebuffer: reset, bank isolation, swap timing,
// simultaneous events, reset during WAIT_VS, and FB_AUTO_CLEAR_EN when defined.
module tb_vga_framebuffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [11:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        swap_req = 1'b0;
   logic        swap_ack;
   logic        busy;
   logic        front_sel;
   logic        v_sync = 1'b1;
   logic [11:0] vga_addr = '0;
   logic [7:0]  vga_data;

   int errs = 0;
   int checks = 0;

`ifdef FB_AUTO_CLEAR_EN
   localparam int EXP_CLR = 4096;
`else
   localparam int EXP_CLR = 0;
`endif

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  a;
      logic [7:0]  b;
   } vec_t;

   vec_t tbl [6];

   vga_framebuffer #(
      .PIX_W            (8),
      .ADDR_W           (12),
      .VSYNC_ACTIVE_LOW (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .swap_req  (swap_req),
      .swap_ack  (swap_ack),
      .busy      (busy),
      .front_sel (front_sel),
      .v_sync    (v_sync),
      .vga_addr  (vga_addr),
      .vga_data  (vga_data)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_px(input logic [11:0] addr, input logic [7:0] data);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_data  = data;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic read_px(input logic [11:0] addr, output logic [7:0] data);
      vga_addr = addr;
      @(negedge clk);
      data = vga_data;
   endtask

   // Entered and left on a negedge with the DUT idle.
   task automatic do_swap(input int wait_cyc, input bit extra_req, input bit with_wr,
                          input string tag);
      logic exp_front;
      int   bad;
      int   n;
      bit   got;
      exp_front = ~front_sel;
      bad = 0;
      got = 1'b0;
      swap_req = 1'b1;
      if (with_wr) begin
         wr_valid = 1'b1;
         wr_addr  = 12'hFFF;
         wr_data  = 8'h3C;
      end
      @(negedge clk);
      swap_req = 1'b0;
      wr_valid = 1'b0;
      for (int i = 0; i < wait_cyc; i++) begin
         if (!busy || wr_ready || swap_ack) bad++;
         if (extra_req) swap_req = (i >= 2 && i < 5);
         @(negedge clk);
      end
      swap_req = 1'b0;
      chk({tag, "_wait_busy"}, bad, 0);
      v_sync = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = swap_ack;
      end
      chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
      chk({tag, "_front_sel"}, {31'd0, front_sel}, {31'd0, exp_front});
      v_sync = 1'b1;
      n = wr_ready ? 0 : 1;
      @(negedge clk);
      chk({tag, "_ack_one_cycle"}, {31'd0, swap_ack}, 32'd0);
      while (!wr_ready && n < 5000) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_clear_cycles"}, n, EXP_CLR);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (swap_ack || busy) bad++;
         @(negedge clk);
      end
      chk({tag, "_quiet_after"}, bad, 0);
   endtask

   initial begin
      logic [7:0] rd;
      int bad;
      int acks;

      tbl[0] = '{12'h041, 8'hA5, 8'h5A};
      tbl[1] = '{12'h000, 8'h01, 8'hFE};
      tbl[2] = '{12'h03F, 8'h80, 8'h7F};
      tbl[3] = '{12'hFC0, 8'h7F, 8'h80};
      tbl[4] = '{12'h7E5, 8'hC3, 8'h3C};
      tbl[5] = '{12'h123, 8'h00, 8'hFF};

      // Reset
      repeat (2) @(negedge clk);
      chk("rst_vga_data", {24'd0, vga_data}, 32'd0);
      chk("rst_swap_ack", {31'd0, swap_ack}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_front_sel", {31'd0, front_sel}, 32'd0);
      chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // Swap 1 with a 100-cycle v_sync delay; front becomes bank 1
      do_swap(100, 1'b0, 1'b0, "swap1");
      foreach (tbl[i]) write_px(tbl[i].addr, tbl[i].b);

      // Swap 2 with a redundant swap_req during WAIT_VS; front becomes bank 0
      do_swap(10, 1'b1, 1'b0, "swap2");
      foreach (tbl[i]) write_px(tbl[i].addr, tbl[i].a);
      foreach (tbl[i]) begin
         read_px(tbl[i].addr, rd);
         chk($sformatf("iso_%03h", tbl[i].addr), {24'd0, rd}, {24'd0, tbl[i].b});
      end

      // Swap 3 with a write in the request cycle; front becomes bank 1
      do_swap(20, 1'b0, 1'b1, "swap3");
      foreach (tbl[i]) begin
         read_px(tbl[i].addr, rd);
         chk($sformatf("post_swap_%03h", tbl[i].addr), {24'd0, rd}, {24'd0, tbl[i].a});
      end
      read_px(12'hFFF, rd);
      chk("same_cycle_write_fff", {24'd0, rd}, 32'h3C);

`ifdef FB_AUTO_CLEAR_EN
      for (int i = 0; i < 4096; i++) write_px(i[11:0], 8'hFF);
      do_swap(5, 1'b0, 1'b0, "swap4");
      do_swap(5, 1'b0, 1'b0, "swap5");
      do_swap(5, 1'b0, 1'b0, "swap6");
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
         read_px(i[11:0], rd);
         if (rd !== 8'h00) bad++;
      end
      chk("cleared_bank_nonzero", bad, 0);
      do_swap(5, 1'b0, 1'b0, "swap7");
`endif

      // Reset while waiting for v_sync (front_sel is 1 here)
      chk("pre_rst_front_sel", {31'd0, front_sel}, 32'd1);
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("midrst_front_sel", {31'd0, front_sel}, 32'd0);
      chk("midrst_swap_ack", {31'd0, swap_ack}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      v_sync = 1'b0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (swap_ack) acks++;
      end
      v_sync = 1'b1;
      chk("midrst_no_ack", acks, 0);
      chk("midrst_front_hold", {31'd0, front_sel}, 32'd0);
      chk("midrst_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/vga_framebuffer.md
Name: vga_framebuffer

Overview:
- Double-buffered 64x64 8-bit pixel store sitting directly upstream of the VGA scan-out stage.
- Serves the scan-out read port (vga_addr in, vga_data out) from the front bank.
- Accepts pixel writes from the GPU core into the back bank.
- Exchanges the banks only at a vertical-sync boundary, so a displayed frame never tears.

Parameters:
- PIX_W, 8, pixel width; equals the REG_RANGE width.
- ADDR_W, 12, pixel address width; {y[5:0], x[5:0]}, equals the ADDR_RANGE width.
- VSYNC_ACTIVE_LOW, 1, 1: v_sync asserts low; 0: asserts high.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous reset, active-high.
- wr_valid  in  1  GPU write request.
- wr_ready  out  1  block can accept a write this cycle.
- wr_addr  in  ADDR_W  back-bank pixel address.
- wr_data  in  PIX_W  pixel value.
- swap_req  in  1  request bank exchange; sampled only when busy=0.
- swap_ack  out  1  one-cycle pulse when the exchange takes effect.
- busy  out  1  swap pending or clear in progress.
- front_sel  out  1  bank currently displayed.
- v_sync  in  1  vertical sync from the VGA timing stage.
- vga_addr  in  ADDR_W  scan-out read address.
- vga_data  out  PIX_W  pixel read from the front bank.

Behaviour:
- Reset, asynchronous active-high: state=IDLE, front_sel=0, swap_ack=0, busy=0, vga_data=0, v_sync edge register set to its deasserted level. wr_ready=1 from the first cycle after release. RAM contents are not reset.
- Storage: 2*2^ADDR_W entries. Physical address = {bank, addr}. Back bank = ~front_sel.
- Read path: vga_data <= mem[{front_sel, vga_addr}] every clk. Latency is 1 cycle. No handshake; reads never stall.
- Write path: a write occurs when wr_valid & wr_ready: mem[{~front_sel, wr_addr}] <= wr_data. Zero latency to storage; visible on the read side only after a swap.
- Read and write always target different banks, so there is no port conflict.
- Frame boundary: a one-cycle internal pulse vs_edge on the deasserted-to-asserted transition of v_sync (polarity per VSYNC_ACTIVE_LOW). v_sync is registered once before edge detection.
- FSM states IDLE, WAIT_VS, CLEAR (CLEAR exists only with the optional feature):
  - IDLE: wr_ready=1, busy=0. When swap_req=1, go to WAIT_VS next cycle. A write in the same cycle as the accepted swap_req still lands in the old back bank.
  - WAIT_VS: wr_ready=0, busy=1; further swap_req is ignored. On vs_edge: toggle front_sel, pulse swap_ack for exactly 1 cycle, go to IDLE (or CLEAR with the feature). The toggled front_sel applies to reads from the next cycle.
  - A vs_edge that arrives in the same cycle the request is accepted in IDLE does not count; the block waits for the next edge.
- swap_req is level-sampled. The requester deasserts it after swap_ack; if still high in IDLE, another swap is queued.
- wr_valid while wr_ready=0: the write is not performed. The requester holds wr_addr and wr_data stable.
- Reset mid-WAIT_VS or mid-CLEAR: abort to IDLE, front_sel=0; the partially cleared bank is undefined.

Optional Feature:
- Macro FB_AUTO_CLEAR_EN.
- Defined: after swap_ack, enter CLEAR. A 12-bit counter writes 0 to mem[{~front_sel, cnt}], one address per cycle, 0..4095. wr_ready=0 and busy=1 throughout. Returns to IDLE in the cycle after cnt=4095 is written, 4096 cycles total. Reads are unaffected.
- Not defined: no CLEAR state and no counter; WAIT_VS returns directly to IDLE; the back bank keeps the previous frame's contents.

Decomposition:
- Shared package / IncAll include: FB_W=64, FB_H=64, PIX_W, ADDR_W, FSM state encodings (IDLE=2'd0, WAIT_VS=2'd1, CLEAR=2'd2).
- One natural sub-module: fb_dpram, a simple dual-port RAM with one synchronous read port and one write port, 2^(ADDR_W+1) x PIX_W, inferable as block RAM.
- FSM, edge detect and clear counter stay in vga_framebuffer.

Test Plan:
- Reset then read: assert rst, release, drive vga_addr=12'h000 -> vga_data=0 during reset; front_sel=0, wr_ready=1, busy=0 after release.
- Write/isolation: write 8'hA5 to 12'h041 in back bank 1, read vga_addr=12'h041 -> vga_data not 8'hA5 (front bank 0). After swap, same read -> 8'hA5 one cycle after the address.
- Swap timing: pulse swap_req in IDLE, v_sync edge 100 cycles later -> busy=1 and wr_ready=0 for those cycles, then swap_ack high for exactly 1 cycle, front_sel 0->1.
- Simultaneous events: wr_valid with 8'h3C @ 12'hFFF in the same cycle as the accepted swap_req -> write lands in the pre-swap back bank; swap_req during WAIT_VS -> exactly one swap_ack.
- Reset mid-operation: assert rst during WAIT_VS -> state IDLE, front_sel=0, no swap_ack.
- FB_AUTO_CLEAR_EN: fill the back bank with 8'hFF, swap twice -> wr_ready=0 for 4096 cycles after the second swap_ack; all 4096 reads of the new back bank return 0 after a third swap.
